pipe_stage_elastic: RTL and testbench

- Parametrised successor to the fixed execute-to-writeback pipeline register.
- Carries PC, ALU result, destination register and memory/write-back control across one stage boundary.
- Adds a valid/ready handshake with a 2-entry skid buffer, flush-to-bubble and bubble-safe control gating.
- Sits between the execute and memory/write-back stages of the 3-stage core. It also serves any later stage boundary that needs back-pressure.

---
 rtl/pipe_stage_elastic_pkg.sv | 26 ++
 rtl/pipe_skid_entry.sv | 44 ++++
 rtl/pipe_stage_elastic.sv | 176 +++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic execute-to-writeback stage boundary.
// pipe_pkg fixes the default field widths and the payload/FSM types.
package pipe_pkg;

  localparam int XLEN_C     = 32;
  localparam int REG_AW_C   = 5;
  localparam int WB_SEL_W_C = 2;

  // Field order is the packing order used on the stage boundary.
  typedef struct packed {
    logic [XLEN_C-1:0]     pc;
    logic [XLEN_C-1:0]     alu;
    logic [REG_AW_C-1:0]   rd;
    logic                  reg_wr;
    logic                  wr_en;
    logic                  rd_en;
    logic [WB_SEL_W_C-1:0] wb_sel;
  } stage_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One storage slot of the elastic stage: payload register plus valid bit.
// Clear wins over load, so a flush can never leave a slot valid.
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);

  logic [W-1:0] data_d, data_q;
  logic         vld_d, vld_q;

  // Next-state: clear drops validity only, load captures data and marks valid.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (ld_i) begin
      data_d = d_i;
      vld_d  = 1'b1;
    end
  end

  // Slot registers; data is zeroed too so outputs read 0 straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between execute and memory/write-back.
// SKID_EN_DEPTH=2: main (M) + skid (S) slots, registered ready_o.
// SKID_EN_DEPTH=1: single register, ready_o = ready_i | ~valid_o.
// Optional macro PIPE_STAGE_PERF_EN adds stall/flush event counters.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REG_AW        = 5,
  parameter int WB_SEL_W      = 2,
  parameter int SKID_EN_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [XLEN-1:0]     alu_i,
  input  logic [REG_AW-1:0]   rd_i,
  input  logic                reg_wr_i,
  input  logic                wr_en_i,
  input  logic                rd_en_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic                flush_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [XLEN-1:0]     alu_o,
  output logic [REG_AW-1:0]   rd_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                reg_wr_o,
  output logic                wr_en_o,
  output logic                rd_en_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  // Same layout as stage_payload_t, but sized from this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     alu;
    logic [REG_AW-1:0]   rd;
    logic                reg_wr;
    logic                wr_en;
    logic                rd_en;
    logic [WB_SEL_W-1:0] wb_sel;
  } pl_t;

  localparam int PW = $bits(pl_t);

  pl_t  in_pl, m_din, m_q;
  logic m_ld, m_clr, m_vld;
  logic acc, emit;

  assign in_pl = {pc_i, alu_i, rd_i, reg_wr_i, wr_en_i, rd_en_i, wb_sel_i};
  assign acc   = valid_i & ready_o;
  assign emit  = valid_o & ready_i;

  pipe_skid_entry #(.W(PW)) u_m (
    .clk   (clk),
    .reset (reset),
    .ld_i  (m_ld),
    .clr_i (m_clr),
    .d_i   (m_din),
    .q_o   (m_q),
    .vld_o (m_vld)
  );

  if (SKID_EN_DEPTH >= 2) begin : g_skid
    stage_state_e state_d, state_q;
    logic         s_ld, s_clr, s_vld;
    pl_t          s_q;

    pipe_skid_entry #(.W(PW)) u_s (
      .clk   (clk),
      .reset (reset),
      .ld_i  (s_ld),
      .clr_i (s_clr),
      .d_i   (in_pl),
      .q_o   (s_q),
      .vld_o (s_vld)
    );

    // Occupancy FSM; flush empties both slots and drops the incoming beat.
    always_comb begin
      state_d = state_q;
      m_din   = in_pl;
      m_ld    = 1'b0;
      m_clr   = 1'b0;
      s_ld    = 1'b0;
      s_clr   = 1'b0;
      if (flush_i) begin
        state_d = EMPTY;
        m_clr   = 1'b1;
        s_clr   = 1'b1;
      end else begin
        case (state_q)
          EMPTY: if (acc) begin
            m_ld    = 1'b1;
            state_d = ONE;
          end
          ONE: case ({acc, emit})
            2'b10: begin s_ld = 1'b1; state_d = FULL; end
            2'b01: begin m_clr = 1'b1; state_d = EMPTY; end
            2'b11: m_ld = 1'b1;
            default: ;
          endcase
          FULL: if (emit) begin
            // Skid slot slides into the head; ready_o is low so no accept here.
            m_din   = s_q;
            m_ld    = 1'b1;
            s_clr   = 1'b1;
            state_d = ONE;
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= EMPTY;
      else        state_q <= state_d;
    end

    // Skid slot occupied means FULL, so ready_o comes straight from a flop.
    assign ready_o = ~s_vld;
  end else begin : g_reg
    // Plain register: reload on accept, clear when drained with nothing behind.
    always_comb begin
      m_din = in_pl;
      m_ld  = acc & ~flush_i;
      m_clr = flush_i | (emit & ~acc);
    end

    assign ready_o = ready_i | ~m_vld;
  end

  assign valid_o  = m_vld;
  assign pc_o     = m_q.pc;
  assign alu_o    = m_q.alu;
  assign rd_o     = m_q.rd;
  assign wb_sel_o = m_q.wb_sel;
  // Bubbles must never write the register file or memory.
  assign reg_wr_o = m_q.reg_wr & m_vld;
  assign wr_en_o  = m_q.wr_en  & m_vld;
  assign rd_en_o  = m_q.rd_en  & m_vld;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

  // Event counters, free-running and wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(valid_o & ~ready_i);
    flush_cnt_d = flush_cnt_q + 32'(flush_i);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic (default DEPTH=2); reference is a 2-deep queue.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset, valid_i, ready_i, flush_i, ready_o, valid_o;
  logic [31:0] pc_o, alu_o;
  logic [4:0]  rd_o;
  logic [1:0]  wb_sel_o;
  logic reg_wr_o, wr_en_o, rd_en_o;
  stage_payload_t in_p;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  stage_payload_t mq[$];

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(in_p.pc), .alu_i(in_p.alu), .rd_i(in_p.rd), .reg_wr_i(in_p.reg_wr),
    .wr_en_i(in_p.wr_en), .rd_en_i(in_p.rd_en), .wb_sel_i(in_p.wb_sel),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .alu_o(alu_o), .rd_o(rd_o), .wb_sel_o(wb_sel_o),
    .reg_wr_o(reg_wr_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  function automatic stage_payload_t rnd_pl();
    stage_payload_t p;
    p.pc     = $urandom;
    p.alu    = $urandom;
    p.rd     = 5'($urandom);
    p.reg_wr = 1'($urandom);
    p.wr_en  = 1'($urandom);
    p.rd_en  = 1'($urandom);
    p.wb_sel = 2'($urandom);
    return p;
  endfunction

  // One clock edge; the queue model updates with the same transfer rules.
  task automatic step();
    bit acc, emt;
    acc = valid_i && (mq.size() < 2);
    emt = (mq.size() > 0) && ready_i;
    @(posedge clk);
    if (flush_i) mq.delete();
    else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(in_p);
    end
    #1;
  endtask

  task automatic test_reset();
    // power-on reset
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      errors++; $display("FAIL por_handshake got v=%b r=%b want v=0 r=1", valid_o, ready_o);
    end
    checks++;
    if ({pc_o, alu_o, rd_o, wb_sel_o, reg_wr_o, wr_en_o, rd_en_o} !== '0) begin
      errors++; $display("FAIL por_outputs got pc=%h alu=%h nonzero", pc_o, alu_o);
    end
    @(negedge clk) reset = 1'b1;
    // fill to FULL, then reset mid-cycle
    ready_i = 1'b0; valid_i = 1'b1;
    in_p = rnd_pl(); in_p.reg_wr = 1'b1; step();
    in_p = rnd_pl(); step();
    valid_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL rst_full_pre got ready_o=%b want 0", ready_o);
    end
    #2 reset = 1'b0; #1;
    mq.delete();
    checks++;
    if ({valid_o, ready_o, reg_wr_o} !== 3'b010) begin
      errors++; $display("FAIL rst_mid got v=%b r=%b reg_wr=%b want 0 1 0", valid_o, ready_o, reg_wr_o);
    end
    checks++;
    if ({pc_o, alu_o, rd_o, wb_sel_o, wr_en_o, rd_en_o} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got pc=%h alu=%h want 0", pc_o, alu_o);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_stream();
    ready_i = 1'b1; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_p = rnd_pl(); in_p.pc = 32'h100 + 32'(4 * i);
      step();
      checks++;
      if ({valid_o, ready_o, pc_o} !== {2'b11, 32'h100 + 32'(4 * i)}) begin
        errors++; $display("FAIL stream_%0d got v=%b r=%b pc=%h want 1 1 %h", i, valid_o, ready_o, pc_o, 32'h100 + 32'(4 * i));
      end
    end
    valid_i = 1'b0; step();
    checks++;
    if (valid_o !== 1'b0) begin
      errors++; $display("FAIL stream_drain got valid_o=%b want 0", valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hA0; exp_pc[1] = 32'hB0; exp_pc[2] = 32'hC0;
    ready_i = 1'b0; valid_i = 1'b1;
    in_p = rnd_pl(); in_p.pc = 32'hA0; step();
    in_p = rnd_pl(); in_p.pc = 32'hB0; step();
    in_p = rnd_pl(); in_p.pc = 32'hC0;
    step();
    checks++;
    if ({valid_o, ready_o, pc_o} !== {2'b10, 32'hA0}) begin
      errors++; $display("FAIL bp_full got v=%b r=%b pc=%h want 1 0 a0", valid_o, ready_o, pc_o);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid_o, pc_o} !== {1'b1, exp_pc[i]}) begin
        errors++; $display("FAIL bp_order_%0d got v=%b pc=%h want 1 %h", i, valid_o, pc_o, exp_pc[i]);
      end
      step();
      if (i == 1) valid_i = 1'b0;
    end
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      errors++; $display("FAIL bp_drain got v=%b r=%b want 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0; valid_i = 1'b1;
    in_p = rnd_pl(); in_p.pc = 32'h11; step();
    in_p = rnd_pl(); in_p.pc = 32'h22; step();
    in_p = rnd_pl(); in_p.pc = 32'hDEAD; flush_i = 1'b1;
    checks++;
    if ({valid_o, ready_o, pc_o} !== {2'b10, 32'h11}) begin
      errors++; $display("FAIL flush_same_cycle got v=%b r=%b pc=%h want 1 0 11", valid_o, ready_o, pc_o);
    end
    step();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    checks++;
    if ({valid_o, ready_o} !== 2'b01) begin
      errors++; $display("FAIL flush_next got v=%b r=%b want 0 1", valid_o, ready_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++; $display("FAIL flush_leak got valid_o=%b pc=%h want 0", valid_o, pc_o);
      end
    end
  endtask

  task automatic test_bubble_gating();
    // leave a drained head holding set control bits
    ready_i = 1'b1; valid_i = 1'b1;
    in_p = rnd_pl(); in_p.reg_wr = 1'b1; in_p.wr_en = 1'b1; in_p.rd_en = 1'b1;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      ready_i = 1'($urandom);
      checks++;
      if ({valid_o, reg_wr_o, wr_en_o, rd_en_o} !== 4'b0) begin
        errors++; $display("FAIL bubble_%0d got v=%b reg_wr=%b wr_en=%b rd_en=%b want 0", i, valid_o, reg_wr_o, wr_en_o, rd_en_o);
      end
    end
  endtask

  task automatic test_random();
    bit exp_v;
    for (int i = 0; i < 400; i++) begin
      valid_i = 1'($urandom);
      ready_i = ($urandom_range(3) != 0);
      flush_i = ($urandom_range(15) == 0);
      in_p = rnd_pl();
      step();
      exp_v = (mq.size() != 0);
      checks++;
      if ({valid_o, ready_o} !== {exp_v, mq.size() < 2}) begin
        errors++; $display("FAIL rand_hs_%0d got v=%b r=%b want %b %b", i, valid_o, ready_o, exp_v, mq.size() < 2);
      end
      checks++;
      if (exp_v) begin
        if ({pc_o, alu_o, rd_o, reg_wr_o, wr_en_o, rd_en_o, wb_sel_o} !== mq[0]) begin
          errors++; $display("FAIL rand_head_%0d got pc=%h alu=%h want pc=%h alu=%h", i, pc_o, alu_o, mq[0].pc, mq[0].alu);
        end
      end else if ({reg_wr_o, wr_en_o, rd_en_o} !== 3'b0) begin
        errors++; $display("FAIL rand_gate_%0d got ctrl=%b want 000", i, {reg_wr_o, wr_en_o, rd_en_o});
      end
    end
    flush_i = 1'b0; valid_i = 1'b0;
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    @(negedge clk) reset = 1'b0;
    mq.delete();
    @(negedge clk) reset = 1'b1;
    ready_i = 1'b0; valid_i = 1'b1; in_p = rnd_pl(); step();
    valid_i = 1'b0;
    repeat (5) step();
    ready_i = 1'b1;
    flush_i = 1'b1; step();
    flush_i = 1'b0; step();
    flush_i = 1'b1; step();
    flush_i = 1'b0;
    checks++;
    if ({stall_cnt_o, flush_cnt_o} !== {32'd5, 32'd2}) begin
      errors++; $display("FAIL perf_cnt got stall=%0d flush=%0d want 5 2", stall_cnt_o, flush_cnt_o);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; in_p = '0;
    #12;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble_gating();
    test_random();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
